// File: rtl/ball_field.sv
// Four bouncing balls: frame-synchronous motion plus a per-pixel
// classifier that feeds the colour mapper.
module ball_field #(
  parameter int BALL_SIZE = 4,
  parameter int STEP      = 1,
  parameter int X_MIN     = 0,
  parameter int X_MAX     = 639,
  parameter int Y_MIN     = 0,
  parameter int Y_MAX     = 479
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic [4:0] is_ball
);

  localparam int NB = 4;

  localparam logic signed [10:0] BS  = 11'(BALL_SIZE);
  localparam logic signed [10:0] STP = 11'(STEP);
  localparam logic signed [10:0] XLO = 11'(X_MIN);
  localparam logic signed [10:0] XHI = 11'(X_MAX);
  localparam logic signed [10:0] YLO = 11'(Y_MIN);
  localparam logic signed [10:0] YHI = 11'(Y_MAX);

  localparam logic [9:0] VP = 10'(STEP);
  localparam logic [9:0] VN = 10'(-STEP);
  localparam logic [9:0] VZ = 10'd0;

  localparam logic [22:0] R2 = 23'(BALL_SIZE * BALL_SIZE);

  localparam logic [9:0] RST_X  [NB] = '{10'd320, 10'd160, 10'd480, 10'd320};
  localparam logic [9:0] RST_Y  [NB] = '{10'd240, 10'd120, 10'd120, 10'd360};
  localparam logic [9:0] RST_VX [NB] = '{VZ, VP, VN, VP};
  localparam logic [9:0] RST_VY [NB] = '{VZ, VP, VP, VN};

  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_D = 8'h07;

  typedef struct packed {
    logic [9:0] pos;
    logic [9:0] vel;
  } axis_t;

  // Bounce overrides the candidate velocity, then the move is clamped
  // so a ball never leaves the playfield even with odd STEP values.
  function automatic axis_t axis_step(
    input logic [9:0]        pos,
    input logic [9:0]        vel,
    input logic signed [10:0] lo,
    input logic signed [10:0] hi
  );
    logic signed [10:0] p;
    logic signed [10:0] v;
    logic signed [10:0] nv;
    logic signed [10:0] np;
    axis_t r;
    p  = signed'({1'b0, pos});
    v  = signed'({vel[9], vel});
    nv = v;
    if (((p + BS) >= hi) && (v > 11'sd0))
      nv = -STP;
    else if ((p <= (lo + BS)) && (v < 11'sd0))
      nv = STP;
    np = p + nv;
    if (np < (lo + BS))
      np = lo + BS;
    else if (np > (hi - BS))
      np = hi - BS;
    r.pos = np[9:0];
    r.vel = nv[9:0];
    return r;
  endfunction

  logic [2:0] sync;
  logic       frame_tick;

  logic [9:0] pos_x [NB];
  logic [9:0] pos_y [NB];
  logic [9:0] vel_x [NB];
  logic [9:0] vel_y [NB];

  logic [9:0] cand_vx [NB];
  logic [9:0] cand_vy [NB];
  axis_t      nx [NB];
  axis_t      ny [NB];

  logic [9:0] steer_vx;
  logic [9:0] steer_vy;
  logic [NB-1:0] hit;

  // Reset high keeps a frame_clk that is already high from looking
  // like a fresh rising edge.
  always_ff @(posedge Clk) begin
    if (Reset)
      sync <= 3'b111;
    else
      sync <= {sync[1:0], frame_clk};
  end

  assign frame_tick = sync[1] & ~sync[2];

  always_comb begin
    steer_vx = vel_x[0];
    steer_vy = vel_y[0];
    unique case (1'b1)
      (keycode == KEY_W): begin
        steer_vx = VZ;
        steer_vy = VN;
      end
      (keycode == KEY_A): begin
        steer_vx = VN;
        steer_vy = VZ;
      end
      (keycode == KEY_S): begin
        steer_vx = VZ;
        steer_vy = VP;
      end
      (keycode == KEY_D): begin
        steer_vx = VP;
        steer_vy = VZ;
      end
      default: ;
    endcase
  end

  always_comb begin
    for (int k = 0; k < NB; k++) begin
      cand_vx[k] = (k == 0) ? steer_vx : vel_x[k];
      cand_vy[k] = (k == 0) ? steer_vy : vel_y[k];
      nx[k] = axis_step(pos_x[k], cand_vx[k], XLO, XHI);
      ny[k] = axis_step(pos_y[k], cand_vy[k], YLO, YHI);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int k = 0; k < NB; k++) begin
        pos_x[k] <= RST_X[k];
        pos_y[k] <= RST_Y[k];
        vel_x[k] <= RST_VX[k];
        vel_y[k] <= RST_VY[k];
      end
    end else if (frame_tick) begin
      for (int k = 0; k < NB; k++) begin
        pos_x[k] <= nx[k].pos;
        pos_y[k] <= ny[k].pos;
        vel_x[k] <= nx[k].vel;
        vel_y[k] <= ny[k].vel;
      end
    end
  end

  for (genvar k = 0; k < NB; k++) begin : g_hit
    logic signed [10:0] dx;
    logic signed [10:0] dy;
    logic signed [21:0] ex;
    logic signed [21:0] ey;
    logic signed [21:0] sx;
    logic signed [21:0] sy;
    logic [22:0]        d2;
    assign dx = signed'({1'b0, DrawX}) - signed'({1'b0, pos_x[k]});
    assign dy = signed'({1'b0, DrawY}) - signed'({1'b0, pos_y[k]});
    assign ex = 22'(dx);
    assign ey = 22'(dy);
    assign sx = ex * ex;
    assign sy = ey * ey;
    assign d2 = {1'b0, sx} + {1'b0, sy};
    assign hit[k] = (d2 <= R2);
  end

  // Lower index wins where balls overlap.
  always_comb begin
    is_ball = 5'd0;
    priority case (1'b1)
      hit[0]:  is_ball = 5'd1;
      hit[1]:  is_ball = 5'd2;
      hit[2]:  is_ball = 5'd3;
      hit[3]:  is_ball = 5'd4;
      default: is_ball = 5'd0;
    endcase
  end

endmodule

// File: tb/tb_ball_field.sv
// Randomised bench for ball_field against a plain-integer model of
// the ball motion and pixel classification rules.
module tb_ball_field;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic [9:0] DrawX = 10'd0;
  logic [9:0] DrawY = 10'd0;
  logic [4:0] is_ball;

  int vectors = 0;
  int miscompares = 0;

  int mx [4];
  int my [4];
  int mvx [4];
  int mvy [4];

  ball_field dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .keycode   (keycode),
    .DrawX     (DrawX),
    .DrawY     (DrawY),
    .is_ball   (is_ball)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    mx = '{320, 160, 480, 320};
    my = '{240, 120, 120, 360};
    mvx = '{0, 1, -1, 1};
    mvy = '{0, 1, 1, -1};
  endfunction

  function automatic void move(inout int p, inout int v,
                               input int lo, input int hi);
    if (p + 4 >= hi && v > 0) v = -1;
    else if (p <= lo + 4 && v < 0) v = 1;
    p = p + v;
    if (p < lo + 4) p = lo + 4;
    if (p > hi - 4) p = hi - 4;
  endfunction

  function automatic void model_tick(input int key);
    case (key)
      'h1A: begin mvx[0] = 0;  mvy[0] = -1; end
      'h04: begin mvx[0] = -1; mvy[0] = 0;  end
      'h16: begin mvx[0] = 0;  mvy[0] = 1;  end
      'h07: begin mvx[0] = 1;  mvy[0] = 0;  end
      default: ;
    endcase
    for (int k = 0; k < 4; k++) begin
      move(mx[k], mvx[k], 0, 639);
      move(my[k], mvy[k], 0, 479);
    end
  endfunction

  function automatic int model_pix(input int x, input int y);
    for (int k = 0; k < 4; k++)
      if ((x - mx[k]) * (x - mx[k]) + (y - my[k]) * (y - my[k]) <= 16)
        return k + 1;
    return 0;
  endfunction

  task automatic probe(input string tag, input int x, input int y);
    @(negedge Clk);
    DrawX = 10'(x);
    DrawY = 10'(y);
    #1;
    check(tag, int'(is_ball), model_pix(x, y));
  endtask

  task automatic probe_const(input string tag, input int x, input int y,
                             input int exp);
    @(negedge Clk);
    DrawX = 10'(x);
    DrawY = 10'(y);
    #1;
    check(tag, int'(is_ball), exp);
  endtask

  task automatic probe_balls(input string tag);
    int px;
    int py;
    for (int k = 0; k < 4; k++) begin
      probe(tag, mx[k], my[k]);
      probe(tag, mx[k] + 4, my[k]);
      probe(tag, mx[k] + 5, my[k]);
      probe(tag, mx[k], my[k] - 4);
      probe(tag, mx[k], my[k] - 5);
      probe(tag, mx[k] - 3, my[k] + 3);
    end
    px = $urandom_range(0, 639);
    py = $urandom_range(0, 479);
    probe(tag, px, py);
  endtask

  task automatic frame(input logic [7:0] key);
    @(negedge Clk);
    keycode = key;
    frame_clk = 1'b1;
    repeat (4) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (4) @(negedge Clk);
    model_tick(int'(key));
  endtask

  task automatic do_reset(input logic fclk);
    @(negedge Clk);
    frame_clk = fclk;
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    model_reset();
  endtask

  task automatic t1_checks(input string tag);
    probe_const({tag, "_b0"}, 320, 240, 1);
    probe_const({tag, "_b1"}, 160, 120, 2);
    probe_const({tag, "_b2"}, 480, 120, 3);
    probe_const({tag, "_b3"}, 320, 360, 4);
    probe_const({tag, "_bg"}, 0, 0, 0);
    probe_const({tag, "_edge_in"}, 324, 240, 1);
    probe_const({tag, "_edge_out"}, 325, 240, 0);
  endtask

  function automatic logic [7:0] rand_key();
    logic [7:0] keys [6];
    keys = '{8'h1A, 8'h04, 8'h16, 8'h07, 8'h00, 8'h2C};
    return keys[$urandom_range(0, 5)];
  endfunction

  initial begin
    model_reset();
    do_reset(1'b0);
    t1_checks("t1");

    // Reset with frame_clk high must not create a tick.
    do_reset(1'b1);
    repeat (5) @(negedge Clk);
    probe_const("t2_hold_b1", 165, 120, 0);
    probe("t2_hold", 160, 120);
    frame_clk = 1'b0;
    repeat (4) @(negedge Clk);
    frame(8'h00);
    probe_const("t2_b1_moved", 165, 121, 2);
    probe_const("t2_b2_moved", 475, 121, 3);
    probe_balls("t2");

    for (int i = 0; i < 3; i++) frame(8'h07);
    probe_const("t3_d", 327, 240, 1);
    probe_balls("t3a");
    for (int i = 0; i < 2; i++) frame(8'h00);
    probe_const("t3_keep", 329, 240, 1);
    probe_balls("t3b");

    for (int i = 0; i < 400; i++) begin
      frame(8'h04);
      if (i >= 380) begin
        probe("t4_left", 0, my[0]);
        probe("t4_wall", mx[0] - 4, my[0]);
      end
    end
    probe_balls("t4");

    // Park ball0 at x=280 while ball1 crosses it at tick 120.
    do_reset(1'b0);
    for (int i = 0; i < 40; i++) frame(8'h04);
    for (int i = 0; i < 40; i++) begin
      frame(8'h07);
      frame(8'h04);
    end
    probe_const("t5_overlap", 280, 240, 1);
    probe("t5_b1_side", 284, 240);
    probe_balls("t5");

    do_reset(1'b0);
    for (int i = 0; i < 150; i++) begin
      frame(rand_key());
      if (i % 5 == 0) probe_balls("rand");
    end

    for (int i = 0; i < 50; i++) frame(rand_key());
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();
    t1_checks("t6");
    probe_balls("t6");

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
